rat_ckpt: RTL
=============

// Module: rat_ckpt
// PURPOSE
//  Parametrised register alias table (RAT) with multi-port reads and branch checkpoints.
//  Sits between decode and ROB/issue. Tracks per architectural register whether the value
//  is committed (value held here) or pending (ROB tag held here).
//  Snapshots the busy/tag map per branch for single-cycle mispredict recovery; full flush on exception.
// PARAMETERS
//  NREG   32  architectural registers; reg 0 hardwired to zero; AW = $clog2(NREG)
//  XLEN   32  data width
//  ROB_W  4   ROB index width (matches `ROB_ENTRY_WIDTH)
//  NRD    2   read ports
//  NCKPT  4   checkpoint slots (power of 2); CW = $clog2(NCKPT)
// PORTS
//  clk        in  1          clock
//  rst        in  1          async active-high reset
//  flush      in  1          exception rollback: all regs valid, all checkpoints freed
//  raddr      in  NRD*AW     read addresses, port p = bits [p*AW +: AW]
//  rvalid     out NRD        reg committed (data valid)
//  rdata      out NRD*XLEN   committed value
//  rrob       out NRD*ROB_W  producing ROB tag when !rvalid, else 0
//  dec_we     in  1          rename dest: waddr -> rob_idx
//  waddr      in  AW         dest register
//  rob_idx    in  ROB_W      ROB tag allocated to dest
//  cm_we      in  1          ROB commit
//  cm_addr    in  AW         committed register
//  cm_data    in  XLEN       committed value
//  cm_rob     in  ROB_W      committing ROB tag
//  ck_req     in  1          take checkpoint (branch decoded)
//  ck_id      out CW         slot granted to ck_req this cycle (= tail pointer)
//  ck_full    out 1          all slots busy; ck_req ignored while high
//  ck_release in  1          oldest checkpoint retired (branch correct/committed)
//  ck_restore in  1          mispredict: restore map from slot ck_rid
//  ck_rid     in  CW         slot to restore
// BEHAVIOUR
//  State: Value[NREG], Busy[NREG], Tag[NREG]; per slot SBusy/STag copies; head, tail, count.
//  Reset (async): Busy=0, Value=0, Tag=0, all slots free, head=tail=count=0;
//   outputs then: rvalid all 1, rdata 0, rrob 0, ck_id 0, ck_full 0.
//  Reads combinational from pre-edge state; same-cycle dec_we not visible. raddr=0: valid, 0, 0.
//  Priority per edge: rst > flush > ck_restore > normal (commit, decode, checkpoint, release).
//  Commit (cm_addr!=0): Value[cm_addr]<=cm_data always; if Busy && Tag==cm_rob then Busy<=0,
//   Tag<=0; same tag-match clear applied to every live slot (SBusy/STag) so restores never resurrect
//   a committed producer.
//  Decode (waddr!=0, not flush/restore): Busy<=1, Tag<=rob_idx; beats same-cycle commit to same reg.
//  ck_req && !ck_full: slot[tail] <= next-state map (includes same-cycle commit and decode);
//   tail<=tail+1 (wraps mod NCKPT), count+1. ck_full = (count==NCKPT).
//  ck_release: head<=head+1, count-1; release with count==0 is ignored.
//  ck_restore: Busy/Tag <= slot[ck_rid] with same-cycle commit clear applied; Value unaffected;
//   tail<=ck_rid; slots ck_rid..tail-1 freed; same-cycle dec_we/ck_req dropped;
//   same-cycle ck_release still advances head; count = (ck_rid - head') mod NCKPT (0 if ck_rid==head').
//  Restoring a freed slot, or ck_release with ck_rid==head, is illegal (assertion).
//  flush: Busy=0, Tag=0, head=tail=count=0; Value kept; commit in same cycle still writes Value.
// CONFIGURATION
//  RAT_BYPASS_EN defined: read of raddr==cm_addr (!=0) while cm_we returns rvalid=1,
//   rdata=cm_data, rrob=0 in the same cycle (commit-to-rename forwarding).
//  Undefined: reads return table state only; commit visible next cycle. Default: undefined.
// TESTING
//  reset, read r5 -> rvalid=1, rdata=0, rrob=0; ck_full=0, ck_id=0.
//  dec_we r5->tag3; next cycle read r5 -> rvalid=0, rrob=3; commit r5 tag3 data 0xAB -> rvalid=1, 0xAB.
//  r5->tag3 then r5->tag7; commit tag3 data 1 -> Value=1 but rvalid=0, rrob=7 (stale commit).
//  ck_req (id0), dec r6->tag2, commit r6 tag2 later... ck_restore id0 -> r6 valid, count=0.
//  ck_req with r8 busy tag4, commit tag4, ck_restore -> r8 valid (slot tag-clear applied).
//  4x ck_req -> ck_full=1, 5th ignored, ck_id stays 0; ck_release -> ck_full=0.
//  RAT_BYPASS_EN: cm_we r9 0x55 with raddr r9 same cycle -> rvalid=1, rdata=0x55 combinationally.

Source files
------------

// File: rtl/rat_ckpt.sv
// rat_ckpt: register alias table with branch checkpoints.
//   Tracks, per architectural register, whether the committed value is held
//   here (valid) or a pending ROB tag produces it (busy). Up to NCKPT busy/tag
//   snapshots are kept in a circular buffer for single-cycle mispredict
//   recovery; flush drops every pending producer and every checkpoint.
// Ports:
//   clk, rst (async, active high), flush
//   raddr/rvalid/rdata/rrob        NRD combinational read ports
//   dec_we, waddr, rob_idx         rename a destination to a ROB tag
//   cm_we, cm_addr, cm_data, cm_rob  ROB commit
//   ck_req, ck_id, ck_full         checkpoint allocation (ck_id = tail)
//   ck_release                     retire oldest checkpoint
//   ck_restore, ck_rid             restore map from a checkpoint slot
// Optional feature: define RAT_BYPASS_EN to forward a same-cycle commit to
// the read ports (rvalid=1, rdata=cm_data, rrob=0).
module rat_ckpt #(
  parameter int NREG  = 32,
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int NRD   = 2,
  parameter int NCKPT = 4,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(NCKPT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD-1:0]      rvalid,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD*ROB_W-1:0] rrob,
  input  logic                dec_we,
  input  logic [AW-1:0]       waddr,
  input  logic [ROB_W-1:0]    rob_idx,
  input  logic                cm_we,
  input  logic [AW-1:0]       cm_addr,
  input  logic [XLEN-1:0]     cm_data,
  input  logic [ROB_W-1:0]    cm_rob,
  input  logic                ck_req,
  output logic [CW-1:0]       ck_id,
  output logic                ck_full,
  input  logic                ck_release,
  input  logic                ck_restore,
  input  logic [CW-1:0]       ck_rid
);

  logic [XLEN-1:0]  value [NREG];
  logic [NREG-1:0]  busy;
  logic [ROB_W-1:0] tag   [NREG];
  logic [NREG-1:0]  sbusy [NCKPT];
  logic [ROB_W-1:0] stag  [NCKPT][NREG];
  logic [CW-1:0]    head, tail;
  logic [CW:0]      count;

  logic             cm_fire, take, rel, byp_en;
  logic [CW-1:0]    head_nxt, rcount, rid_off;
  logic [NREG-1:0]  nbusy, rbusy;
  logic [ROB_W-1:0] ntag [NREG];
  logic [ROB_W-1:0] rtag [NREG];

  assign cm_fire  = cm_we && (cm_addr != '0);
  assign ck_full  = (count == (CW+1)'(NCKPT));
  assign ck_id    = tail;
  assign take     = ck_req && !ck_full;
  assign rel      = ck_release && (count != '0);
  assign head_nxt = head + CW'(rel);
  assign rcount   = ck_rid - head_nxt;
  assign rid_off  = ck_rid - head;

`ifdef RAT_BYPASS_EN
  assign byp_en = cm_fire;
`else
  assign byp_en = 1'b0;
`endif

  // Next-cycle map for the normal path (commit clear, then decode wins),
  // and the restored map (snapshot with this cycle's commit clear applied).
  always_comb begin
    nbusy = busy;
    rbusy = sbusy[ck_rid];
    for (int unsigned i = 0; i < NREG; i++) begin
      ntag[i] = tag[i];
      rtag[i] = stag[ck_rid][i];
    end
    if (cm_fire && busy[cm_addr] && tag[cm_addr] == cm_rob) begin
      nbusy[cm_addr] = 1'b0;
      ntag[cm_addr]  = '0;
    end
    if (dec_we && waddr != '0) begin
      nbusy[waddr] = 1'b1;
      ntag[waddr]  = rob_idx;
    end
    if (cm_fire && rbusy[cm_addr] && rtag[cm_addr] == cm_rob) begin
      rbusy[cm_addr] = 1'b0;
      rtag[cm_addr]  = '0;
    end
  end

  always_comb begin
    rvalid = '1;
    rdata  = '0;
    rrob   = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (raddr[p*AW +: AW] != '0) begin
        if (byp_en && raddr[p*AW +: AW] == cm_addr) begin
          rdata[p*XLEN +: XLEN] = cm_data;
        end else begin
          rvalid[p]             = !busy[raddr[p*AW +: AW]];
          rdata[p*XLEN +: XLEN] = value[raddr[p*AW +: AW]];
          rrob[p*ROB_W +: ROB_W] = busy[raddr[p*AW +: AW]] ? tag[raddr[p*AW +: AW]] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
      for (int unsigned s = 0; s < NCKPT; s++) begin
        sbusy[s] <= '0;
        for (int unsigned i = 0; i < NREG; i++) stag[s][i] <= '0;
      end
    end else begin
      if (cm_fire) value[cm_addr] <= cm_data;
      if (flush) begin
        busy  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int unsigned i = 0; i < NREG; i++) tag[i] <= '0;
      end else begin
        // A committing producer is scrubbed from every snapshot so a later
        // restore cannot mark its register pending again.
        for (int unsigned s = 0; s < NCKPT; s++) begin
          if (cm_fire && sbusy[s][cm_addr] && stag[s][cm_addr] == cm_rob) begin
            sbusy[s][cm_addr] <= 1'b0;
            stag[s][cm_addr]  <= '0;
          end
        end
        head <= head_nxt;
        if (ck_restore) begin
          busy  <= rbusy;
          for (int unsigned i = 0; i < NREG; i++) tag[i] <= rtag[i];
          tail  <= ck_rid;
          count <= {1'b0, rcount};
        end else begin
          busy <= nbusy;
          for (int unsigned i = 0; i < NREG; i++) tag[i] <= ntag[i];
          if (take) begin
            sbusy[tail] <= nbusy;
            for (int unsigned i = 0; i < NREG; i++) stag[tail][i] <= ntag[i];
            tail <= tail + CW'(1);
          end
          count <= count + (CW+1)'(take) - (CW+1)'(rel);
        end
      end
    end
  end

  // Restore target must be a live slot and must not be retired in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && !flush && ck_restore) begin
      assert ({1'b0, rid_off} < count);
      assert (!(ck_release && ck_rid == head));
    end
  end

endmodule
